// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
package instruction_fetch_unit_pkg;

   localparam int ADDRESS_LEN = 32;

   // All-zero word is the NOP encoding used for bubbles.
   localparam logic [ADDRESS_LEN-1:0] NOP = '0;

   // Byte stride between sequential instruction words.
   localparam logic [ADDRESS_LEN-1:0] PC_INC = 32'd4;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: captured instruction, its PC+4 and a valid flag.
module if_id_register
   import instruction_fetch_unit_pkg::*;
#(
   parameter int ADDR_LEN = ADDRESS_LEN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                freeze,
   input  logic                flush,
   input  logic [ADDR_LEN-1:0] pc_in,
   input  logic [ADDR_LEN-1:0] instruction_in,
   output logic [ADDR_LEN-1:0] pc_out,
   output logic [ADDR_LEN-1:0] instruction_out,
   output logic                valid_out
);

   // Flush beats freeze so a redirect can never be held off by a stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_out          <= '0;
         instruction_out <= ADDR_LEN'(NOP);
         valid_out       <= 1'b0;
      end else if (flush) begin
         pc_out          <= '0;
         instruction_out <= ADDR_LEN'(NOP);
         valid_out       <= 1'b0;
      end else if (!freeze) begin
         pc_out          <= pc_in;
         instruction_out <= instruction_in;
         valid_out       <= 1'b1;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, next-PC selection, boot FSM, IF/ID register and
// a saturating count of instructions accepted into IF/ID.
//
// state | meaning
// BOOT  | first edge after reset; PC holds (unless redirected), no capture
// RUN   | normal fetch; left only through reset
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                ADDR_LEN     = ADDRESS_LEN,
   parameter logic [ADDR_LEN-1:0] RESET_VECTOR = '0,
   parameter int                CNT_LEN      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                freeze,
   input  logic                branch_taken,
   input  logic [ADDR_LEN-1:0] branch_address,
   input  logic                flush,
   output logic [ADDR_LEN-1:0] imem_addr,
   input  logic [ADDR_LEN-1:0] imem_data,
   output logic [ADDR_LEN-1:0] pc_out,
   output logic [ADDR_LEN-1:0] instruction_out,
   output logic                valid_out,
   output logic [CNT_LEN-1:0]  fetch_count
);

   fetch_state_t        state_q, state_d;
   logic [ADDR_LEN-1:0] pc_q, pc_d;
   logic [ADDR_LEN-1:0] pc_plus4;
   logic [ADDR_LEN-1:0] branch_aligned;
   logic                ifid_clear;
   logic                ifid_hold;
   logic                capture;

   assign pc_plus4       = pc_q + ADDR_LEN'(PC_INC);
   assign branch_aligned = branch_address & ~ADDR_LEN'(2'b11);
   assign imem_addr      = {pc_q[ADDR_LEN-1:2], 2'b00};

   assign ifid_clear = flush | branch_taken;
   assign ifid_hold  = freeze | (state_q == BOOT);
   assign capture    = (state_q == RUN) & ~freeze & ~ifid_clear;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= BOOT;
      else     state_q <= state_d;
   end

   // Next state: BOOT lasts one edge, RUN is absorbing.
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   // Next PC: redirect, then stall / boot hold, then sequential.
   always_comb begin
      pc_d = pc_q;
      if (branch_taken)                        pc_d = branch_aligned;
      else if (!freeze && (state_q == RUN))    pc_d = pc_plus4;
   end

   // Program counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_q <= RESET_VECTOR;
      else     pc_q <= pc_d;
   end

   // Accepted-instruction counter, saturating at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             fetch_count <= '0;
      else if (capture && (~fetch_count != '0)) fetch_count <= fetch_count + 1'b1;
   end

   if_id_register #(.ADDR_LEN(ADDR_LEN)) u_if_id (
      .clk             (clk),
      .rst             (rst),
      .freeze          (ifid_hold),
      .flush           (ifid_clear),
      .pc_in           (pc_plus4),
      .instruction_in  (imem_data),
      .pc_out          (pc_out),
      .instruction_out (instruction_out),
      .valid_out       (valid_out)
   );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a 16-bit-counter and a 4-bit-counter
// instance share stimulus; a reference model is compared every negedge,
// and directed steps add literal expectations.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_address = '0;
   logic        flush = 1'b0;

   logic [31:0] imem_addr, imem_data, pc_out, instruction_out;
   logic        valid_out;
   logic [15:0] fetch_count;

   logic [31:0] imem_addr4, imem_data4, pc_out4, instruction_out4;
   logic        valid_out4;
   logic [3:0]  fetch_count4;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h0:   return 32'hE3A00015;
         32'h4:   return 32'hE3A01A01;
         32'h8:   return 32'hE3A0DC02;
         32'h1C:  return 32'hEAFFFFFF;
         default: return 32'hA000_0000 ^ a;
      endcase
   endfunction

   assign imem_data  = mem(imem_addr);
   assign imem_data4 = mem(imem_addr4);

   instruction_fetch_unit dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_address(branch_address), .flush(flush),
      .imem_addr(imem_addr), .imem_data(imem_data), .pc_out(pc_out),
      .instruction_out(instruction_out), .valid_out(valid_out),
      .fetch_count(fetch_count)
   );

   instruction_fetch_unit #(.CNT_LEN(4)) dut4 (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_address(branch_address), .flush(flush),
      .imem_addr(imem_addr4), .imem_data(imem_data4), .pc_out(pc_out4),
      .instruction_out(instruction_out4), .valid_out(valid_out4),
      .fetch_count(fetch_count4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the fetch stage must hold after each edge.
   logic [31:0] m_pc = '0, m_pcout = '0, m_instr = '0;
   logic        m_valid = 1'b0;
   bit          m_booted = 1'b0;
   int          m_n = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = 32'h0; m_pcout = '0; m_instr = '0; m_valid = 1'b0;
         m_booted = 1'b0; m_n = 0;
      end else begin
         if (flush || branch_taken) begin
            m_pcout = '0; m_instr = '0; m_valid = 1'b0;
         end else if (m_booted && !freeze) begin
            m_pcout = m_pc + 32'd4; m_instr = mem(m_pc); m_valid = 1'b1;
            m_n++;
         end
         if (branch_taken)             m_pc = {branch_address[31:2], 2'b00};
         else if (m_booted && !freeze) m_pc = m_pc + 32'd4;
         m_booted = 1'b1;
      end
   end

   // Per-cycle comparison against the model for both instances.
   always @(negedge clk) begin
      chk("imem_addr",     imem_addr,       m_pc);
      chk("pc_out",        pc_out,          m_pcout);
      chk("instruction",   instruction_out, m_instr);
      chk("valid",         {31'b0, valid_out}, {31'b0, m_valid});
      chk("count16",       {16'b0, fetch_count}, (m_n > 65535) ? 32'd65535 : m_n);
      chk("imem_addr4",    imem_addr4,      m_pc);
      chk("valid4",        {31'b0, valid_out4}, {31'b0, m_valid});
      chk("count4",        {28'b0, fetch_count4}, (m_n > 15) ? 32'd15 : m_n);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      tick(); tick();
      chk("rst_addr",  imem_addr, 32'h0);
      chk("rst_valid", {31'b0, valid_out}, 32'h0);
      chk("rst_count", {16'b0, fetch_count}, 32'h0);
      rst = 1'b0;

      // BOOT edge: PC holds, nothing captured.
      tick();
      chk("boot_addr",  imem_addr, 32'h0);
      chk("boot_valid", {31'b0, valid_out}, 32'h0);
      tick();
      chk("cap0_pc",    pc_out, 32'h4);
      chk("cap0_instr", instruction_out, 32'hE3A00015);
      chk("cap0_valid", {31'b0, valid_out}, 32'h1);
      tick();
      chk("cap1_pc",    pc_out, 32'h8);
      chk("cap1_instr", instruction_out, 32'hE3A01A01);
      chk("cap1_count", {16'b0, fetch_count}, 32'd2);
      chk("cap1_addr",  imem_addr, 32'h8);

      // Stall three cycles at pc = 8.
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("frz_addr",  imem_addr, 32'h8);
         chk("frz_pc",    pc_out, 32'h8);
         chk("frz_instr", instruction_out, 32'hE3A01A01);
         chk("frz_count", {16'b0, fetch_count}, 32'd2);
      end
      freeze = 1'b0;
      tick();
      chk("resume_pc",    pc_out, 32'hC);
      chk("resume_instr", instruction_out, 32'hE3A0DC02);
      chk("resume_count", {16'b0, fetch_count}, 32'd3);

      // Redirect to a misaligned target while stalled.
      branch_taken = 1'b1; branch_address = 32'h1D; freeze = 1'b1;
      tick();
      branch_taken = 1'b0; freeze = 1'b0;
      chk("br_addr",  imem_addr, 32'h1C);
      chk("br_pc",    pc_out, 32'h0);
      chk("br_instr", instruction_out, 32'h0);
      chk("br_valid", {31'b0, valid_out}, 32'h0);
      tick();
      chk("br_cap_pc",    pc_out, 32'h20);
      chk("br_cap_instr", instruction_out, 32'hEAFFFFFF);
      chk("br_cap_valid", {31'b0, valid_out}, 32'h1);
      chk("br_cap_count", {16'b0, fetch_count}, 32'd4);

      // Flush alone at pc = 4.
      branch_taken = 1'b1; branch_address = 32'h4;
      tick();
      branch_taken = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_addr",  imem_addr, 32'h8);
      chk("fl_valid", {31'b0, valid_out}, 32'h0);
      chk("fl_count", {16'b0, fetch_count}, 32'd4);

      // Wrap at top of the address space.
      branch_taken = 1'b1; branch_address = 32'hFFFF_FFFC;
      tick();
      branch_taken = 1'b0;
      chk("wr_pre_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("wr_addr",  imem_addr, 32'h0);
      chk("wr_pc",    pc_out, 32'h0);
      chk("wr_instr", instruction_out, 32'hA000_0000 ^ 32'hFFFF_FFFC);
      chk("wr_count", {16'b0, fetch_count}, 32'd5);

      // Twenty free-running cycles: 4-bit counter saturates.
      for (int i = 0; i < 20; i++) tick();
      chk("sat_count4",  {28'b0, fetch_count4}, 32'hF);
      chk("sat_count16", {16'b0, fetch_count}, 32'd25);

      // Asynchronous reset between edges.
      #2;
      rst = 1'b1;
      #1;
      chk("arst_count",  {16'b0, fetch_count}, 32'h0);
      chk("arst_count4", {28'b0, fetch_count4}, 32'h0);
      chk("arst_valid",  {31'b0, valid_out}, 32'h0);
      chk("arst_addr",   imem_addr, 32'h0);
      tick();
      rst = 1'b0;
      tick(); tick();
      chk("post_pc",    pc_out, 32'h4);
      chk("post_instr", instruction_out, 32'hE3A00015);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
